// File: rtl/io_stage_if.sv
// Boundary signals of the memory-response stage: EX entry bus, data-memory read
// response, WB handshake/flush, the io_to_wb bus and the ID back-pass bus.
interface io_stage_if;
    // EX -> IO entry
    logic        ex_valid;
    logic [31:0] ex_program_count;
    logic [31:0] ex_alu_result;
    logic [2:0]  ex_load_type;
    logic [31:0] ex_rt_value;
    logic        ex_rf_write_enabled;
    logic [4:0]  ex_rf_address;
    logic        ex_data_request_issued;
    logic        ex_exception_valid;
    logic [4:0]  ex_exception_code;
    logic        ex_eret_flush;
    logic        ex_in_delay_slot;
    logic        ex_move_to_cp0;
    logic [4:0]  ex_cp0_address_register;
    logic [2:0]  ex_cp0_address_select;
    logic        io_allow_in;

    // data-memory read response and WB side controls
    logic        data_response_valid;
    logic [31:0] data_response_data;
    logic        wb_allow_in;
    logic        flush;

    // IO -> WB
    logic        wb_valid;
    logic [31:0] wb_program_count;
    logic [31:0] wb_final_result;
    logic        wb_rf_write_enabled;
    logic [3:0]  wb_rf_write_strobe;
    logic [4:0]  wb_rf_address;
    logic        wb_exception_valid;
    logic [4:0]  wb_exception_code;
    logic        wb_eret_flush;
    logic        wb_in_delay_slot;
    logic        wb_move_to_cp0;
    logic [4:0]  wb_cp0_address_register;
    logic [2:0]  wb_cp0_address_select;
    logic [31:0] wb_rt_value;

    // IO -> ID back-pass
    logic        bp_valid;
    logic        bp_data_pending;
    logic [4:0]  bp_write_register;
    logic [3:0]  bp_write_strobe;
    logic [31:0] bp_write_data;

    modport master (
        output ex_valid, ex_program_count, ex_alu_result, ex_load_type, ex_rt_value,
               ex_rf_write_enabled, ex_rf_address, ex_data_request_issued,
               ex_exception_valid, ex_exception_code, ex_eret_flush, ex_in_delay_slot,
               ex_move_to_cp0, ex_cp0_address_register, ex_cp0_address_select,
               data_response_valid, data_response_data, wb_allow_in, flush,
        input  io_allow_in,
               wb_valid, wb_program_count, wb_final_result, wb_rf_write_enabled,
               wb_rf_write_strobe, wb_rf_address, wb_exception_valid, wb_exception_code,
               wb_eret_flush, wb_in_delay_slot, wb_move_to_cp0, wb_cp0_address_register,
               wb_cp0_address_select, wb_rt_value,
               bp_valid, bp_data_pending, bp_write_register, bp_write_strobe, bp_write_data
    );

    modport slave (
        input  ex_valid, ex_program_count, ex_alu_result, ex_load_type, ex_rt_value,
               ex_rf_write_enabled, ex_rf_address, ex_data_request_issued,
               ex_exception_valid, ex_exception_code, ex_eret_flush, ex_in_delay_slot,
               ex_move_to_cp0, ex_cp0_address_register, ex_cp0_address_select,
               data_response_valid, data_response_data, wb_allow_in, flush,
        output io_allow_in,
               wb_valid, wb_program_count, wb_final_result, wb_rf_write_enabled,
               wb_rf_write_strobe, wb_rf_address, wb_exception_valid, wb_exception_code,
               wb_eret_flush, wb_in_delay_slot, wb_move_to_cp0, wb_cp0_address_register,
               wb_cp0_address_select, wb_rt_value,
               bp_valid, bp_data_pending, bp_write_register, bp_write_strobe, bp_write_data
    );
endinterface

// File: rtl/io_stage.sv
// Memory-response stage of the 5-stage MIPS core: waits for load data, aligns and
// extends it, and drops responses that belong to instructions killed by a flush.
module io_stage #(
    parameter int DISCARD_WIDTH = 2
) (
    input  logic      clock,
    input  logic      reset,
    io_stage_if.slave bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    localparam logic [2:0] LT_LB  = 3'd1;
    localparam logic [2:0] LT_LBU = 3'd2;
    localparam logic [2:0] LT_LH  = 3'd3;
    localparam logic [2:0] LT_LHU = 3'd4;
    localparam logic [2:0] LT_LW  = 3'd5;
    localparam logic [2:0] LT_LWL = 3'd6;
    localparam logic [2:0] LT_LWR = 3'd7;

    function automatic logic [31:0] f_load_data(input logic [2:0]  lt,
                                                input logic [1:0]  off,
                                                input logic [31:0] d,
                                                input logic [31:0] alu);
        logic [31:0] shifted;
        logic [15:0] half;
        logic [31:0] res;
        shifted = d >> {off, 3'b000};
        half    = off[1] ? d[31:16] : d[15:0];
        case (lt)
            LT_LB:   res = {{24{shifted[7]}}, shifted[7:0]};
            LT_LBU:  res = {24'h000000, shifted[7:0]};
            LT_LH:   res = {{16{half[15]}}, half};
            LT_LHU:  res = {16'h0000, half};
            LT_LW:   res = d;
            LT_LWL:  res = d << {~off, 3'b000};
            LT_LWR:  res = shifted;
            default: res = alu;
        endcase
        return res;
    endfunction

    // lwl/lwr only touch the register bytes the unaligned word actually covers
    function automatic logic [3:0] f_load_strobe(input logic [2:0] lt,
                                                 input logic [1:0] off);
        logic [3:0] s;
        case (lt)
            LT_LWL:  s = 4'b1111 << ~off;
            LT_LWR:  s = 4'b1111 >> off;
            default: s = 4'b1111;
        endcase
        return s;
    endfunction

    logic                     r_io_valid;
    logic [1:0]               r_state;
    logic [DISCARD_WIDTH-1:0] r_discard_count;
    logic [31:0]              r_held_data;

    logic [31:0] r_program_count;
    logic [31:0] r_alu_result;
    logic [2:0]  r_load_type;
    logic [31:0] r_rt_value;
    logic        r_rf_write_enabled;
    logic [4:0]  r_rf_address;
    logic        r_exception_valid;
    logic [4:0]  r_exception_code;
    logic        r_eret_flush;
    logic        r_in_delay_slot;
    logic        r_move_to_cp0;
    logic [4:0]  r_cp0_address_register;
    logic [2:0]  r_cp0_address_select;

    logic        w_resp_take;
    logic        w_ready_go;
    logic        w_allow_in;
    logic        w_latch;
    logic        w_leave;
    logic [31:0] w_word;
    logic [31:0] w_final_result;
    logic [3:0]  w_strobe;
    logic        w_rf_we;
    logic        w_disc_inc;
    logic        w_disc_dec;
    logic        w_disc_max;

    // a response only belongs to the current entry once all stale ones are drained
    assign w_resp_take = bus.data_response_valid && (r_discard_count == '0);
    assign w_ready_go  = r_io_valid && ((r_state != S_WAIT) || w_resp_take);
    assign w_allow_in  = !r_io_valid || (w_ready_go && bus.wb_allow_in);
    assign w_latch     = w_allow_in && bus.ex_valid && !bus.flush;
    assign w_leave     = w_ready_go && bus.wb_allow_in;
    assign w_word      = (r_state == S_HOLD) ? r_held_data : bus.data_response_data;
    assign w_rf_we     = r_rf_write_enabled && !r_exception_valid;

    assign w_final_result = f_load_data(r_load_type, r_alu_result[1:0], w_word, r_alu_result);
    assign w_strobe       = f_load_strobe(r_load_type, r_alu_result[1:0]);

    assign w_disc_inc = bus.flush && r_io_valid && (r_state == S_WAIT) && !w_resp_take;
    assign w_disc_dec = bus.data_response_valid && (r_discard_count != '0);
    assign w_disc_max = (r_discard_count == '1);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_io_valid  <= 1'b0;
            r_state     <= S_IDLE;
            r_held_data <= '0;
        end else if (bus.flush) begin
            r_io_valid <= 1'b0;
            r_state    <= S_IDLE;
        end else if (w_latch) begin
            r_io_valid <= 1'b1;
            r_state    <= (bus.ex_data_request_issued && !bus.ex_exception_valid) ? S_WAIT : S_IDLE;
        end else if (w_leave) begin
            r_io_valid <= 1'b0;
            r_state    <= S_IDLE;
        end else if ((r_state == S_WAIT) && w_resp_take) begin
            r_state     <= S_HOLD;
            r_held_data <= bus.data_response_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_discard_count <= '0;
        end else if (w_disc_inc && !w_disc_dec) begin
            if (!w_disc_max) begin
                r_discard_count <= r_discard_count + DISCARD_WIDTH'(1);
            end
        end else if (!w_disc_inc && w_disc_dec) begin
            r_discard_count <= r_discard_count - DISCARD_WIDTH'(1);
        end
    end

    a_discard_no_overflow: assert property (@(posedge clock) disable iff (reset)
        !(w_disc_inc && !w_disc_dec && w_disc_max));

    always_ff @(posedge clock) begin
        if (w_latch) begin
            r_program_count        <= bus.ex_program_count;
            r_alu_result           <= bus.ex_alu_result;
            r_load_type            <= bus.ex_load_type;
            r_rt_value             <= bus.ex_rt_value;
            r_rf_write_enabled     <= bus.ex_rf_write_enabled;
            r_rf_address           <= bus.ex_rf_address;
            r_exception_valid      <= bus.ex_exception_valid;
            r_exception_code       <= bus.ex_exception_code;
            r_eret_flush           <= bus.ex_eret_flush;
            r_in_delay_slot        <= bus.ex_in_delay_slot;
            r_move_to_cp0          <= bus.ex_move_to_cp0;
            r_cp0_address_register <= bus.ex_cp0_address_register;
            r_cp0_address_select   <= bus.ex_cp0_address_select;
        end
    end

    assign bus.io_allow_in = w_allow_in;

    assign bus.wb_valid                = w_ready_go && !bus.flush;
    assign bus.wb_program_count        = r_program_count;
    assign bus.wb_final_result         = w_final_result;
    assign bus.wb_rf_write_enabled     = w_rf_we;
    assign bus.wb_rf_write_strobe      = w_strobe;
    assign bus.wb_rf_address           = r_rf_address;
    assign bus.wb_exception_valid      = r_exception_valid;
    assign bus.wb_exception_code       = r_exception_code;
    assign bus.wb_eret_flush           = r_eret_flush;
    assign bus.wb_in_delay_slot        = r_in_delay_slot;
    assign bus.wb_move_to_cp0          = r_move_to_cp0;
    assign bus.wb_cp0_address_register = r_cp0_address_register;
    assign bus.wb_cp0_address_select   = r_cp0_address_select;
    assign bus.wb_rt_value             = r_rt_value;

    // ID must stall rather than forward while the load data is still outstanding
    assign bus.bp_valid          = r_io_valid && w_rf_we;
    assign bus.bp_data_pending   = bus.bp_valid && (r_state == S_WAIT) && !w_resp_take;
    assign bus.bp_write_register = r_rf_address;
    assign bus.bp_write_strobe   = w_strobe;
    assign bus.bp_write_data     = w_final_result;

endmodule

// File: tb/tb_io_stage.sv
// Directed bench for io_stage: load alignment, wait/hold handshakes, flush discard,
// exception entries and reset while a load is outstanding.
module tb_io_stage;

    logic clock = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    io_stage_if bus_if ();

    io_stage #(.DISCARD_WIDTH(2)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic ex_clear;
        bus_if.ex_valid                = 1'b0;
        bus_if.ex_program_count        = '0;
        bus_if.ex_alu_result           = '0;
        bus_if.ex_load_type            = '0;
        bus_if.ex_rt_value             = '0;
        bus_if.ex_rf_write_enabled     = 1'b0;
        bus_if.ex_rf_address           = '0;
        bus_if.ex_data_request_issued  = 1'b0;
        bus_if.ex_exception_valid      = 1'b0;
        bus_if.ex_exception_code       = '0;
        bus_if.ex_eret_flush           = 1'b0;
        bus_if.ex_in_delay_slot        = 1'b0;
        bus_if.ex_move_to_cp0          = 1'b0;
        bus_if.ex_cp0_address_register = '0;
        bus_if.ex_cp0_address_select   = '0;
    endtask

    task automatic ex_load(input logic [2:0] lt, input logic [31:0] alu,
                           input logic [4:0] rd, input logic req);
        ex_clear();
        bus_if.ex_valid               = 1'b1;
        bus_if.ex_load_type           = lt;
        bus_if.ex_alu_result          = alu;
        bus_if.ex_program_count       = 32'hBFC0_0000 + alu;
        bus_if.ex_rf_write_enabled    = 1'b1;
        bus_if.ex_rf_address          = rd;
        bus_if.ex_data_request_issued = req;
    endtask

    task automatic resp(input logic v, input logic [31:0] d);
        bus_if.data_response_valid = v;
        bus_if.data_response_data  = d;
    endtask

    initial begin
        reset = 1'b1;
        ex_clear();
        resp(1'b0, 32'h0);
        bus_if.wb_allow_in = 1'b1;
        bus_if.flush       = 1'b0;
        @(negedge clock);
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("reset_allow_in", bus_if.io_allow_in, 1);
        chk("reset_wb_valid", bus_if.wb_valid, 0);
        chk("reset_bp_valid", bus_if.bp_valid, 0);
        chk("reset_pending", bus_if.bp_data_pending, 0);

        // lb with response in the first WAIT cycle
        ex_load(3'd1, 32'h0000_1002, 5'd5, 1'b1);
        #1 chk("lb_allow_in", bus_if.io_allow_in, 1);
        tick();
        ex_clear();
        resp(1'b1, 32'h80FF_7F00);
        #1;
        chk("lb_wb_valid", bus_if.wb_valid, 1);
        chk("lb_result", bus_if.wb_final_result, 32'hFFFF_FFFF);
        chk("lb_strobe", bus_if.wb_rf_write_strobe, 4'b1111);
        chk("lb_bp_valid", bus_if.bp_valid, 1);
        chk("lb_pending", bus_if.bp_data_pending, 0);
        chk("lb_rf_addr", bus_if.wb_rf_address, 5'd5);
        chk("lb_pc", bus_if.wb_program_count, 32'hBFC0_1002);
        tick();
        resp(1'b0, 32'h0);
        #1 chk("lb_wb_valid_after", bus_if.wb_valid, 0);

        // back-to-back lwl / lwr / lh / lbu
        ex_load(3'd6, 32'h0000_2001, 5'd6, 1'b1);
        tick();
        ex_load(3'd7, 32'h0000_2002, 5'd7, 1'b1);
        resp(1'b1, 32'hAABB_CCDD);
        #1;
        chk("lwl_result", bus_if.wb_final_result, 32'hCCDD_0000);
        chk("lwl_strobe", bus_if.wb_rf_write_strobe, 4'b1100);
        chk("lwl_allow_in", bus_if.io_allow_in, 1);
        tick();
        ex_load(3'd3, 32'h0000_2002, 5'd8, 1'b1);
        resp(1'b1, 32'hAABB_CCDD);
        #1;
        chk("lwr_result", bus_if.wb_final_result, 32'h0000_AABB);
        chk("lwr_strobe", bus_if.wb_rf_write_strobe, 4'b0011);
        chk("lwr_bp_strobe", bus_if.bp_write_strobe, 4'b0011);
        tick();
        ex_load(3'd2, 32'h0000_2003, 5'd9, 1'b1);
        resp(1'b1, 32'h8001_7FFF);
        #1 chk("lh_result", bus_if.wb_final_result, 32'hFFFF_8001);
        tick();
        ex_clear();
        resp(1'b1, 32'h8001_7FFF);
        #1 chk("lbu_result", bus_if.wb_final_result, 32'h0000_0080);
        tick();
        resp(1'b0, 32'h0);

        // lw with a 3-cycle response delay
        ex_load(3'd5, 32'h0000_3000, 5'd10, 1'b1);
        tick();
        ex_clear();
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("lw_wait_pending", bus_if.bp_data_pending, 1);
            chk("lw_wait_allow_in", bus_if.io_allow_in, 0);
            chk("lw_wait_wb_valid", bus_if.wb_valid, 0);
            tick();
        end
        resp(1'b1, 32'h1234_5678);
        #1;
        chk("lw_resp_wb_valid", bus_if.wb_valid, 1);
        chk("lw_resp_result", bus_if.wb_final_result, 32'h1234_5678);
        chk("lw_resp_pending", bus_if.bp_data_pending, 0);
        tick();
        resp(1'b0, 32'h0);

        // response while WB stalls for two cycles, then hand-over to an ALU op
        ex_load(3'd5, 32'h0000_4000, 5'd11, 1'b1);
        tick();
        ex_clear();
        bus_if.wb_allow_in = 1'b0;
        resp(1'b1, 32'hCAFE_F00D);
        #1;
        chk("hold0_wb_valid", bus_if.wb_valid, 1);
        chk("hold0_allow_in", bus_if.io_allow_in, 0);
        chk("hold0_result", bus_if.wb_final_result, 32'hCAFE_F00D);
        tick();
        resp(1'b0, 32'hDEAD_BEEF);
        #1;
        chk("hold1_wb_valid", bus_if.wb_valid, 1);
        chk("hold1_result", bus_if.wb_final_result, 32'hCAFE_F00D);
        chk("hold1_allow_in", bus_if.io_allow_in, 0);
        chk("hold1_pending", bus_if.bp_data_pending, 0);
        tick();
        bus_if.wb_allow_in = 1'b1;
        ex_load(3'd0, 32'h55AA_55AA, 5'd12, 1'b0);
        #1;
        chk("hold2_allow_in", bus_if.io_allow_in, 1);
        chk("hold2_wb_valid", bus_if.wb_valid, 1);
        chk("hold2_result", bus_if.wb_final_result, 32'hCAFE_F00D);
        tick();
        ex_clear();
        #1;
        chk("alu_wb_valid", bus_if.wb_valid, 1);
        chk("alu_result", bus_if.wb_final_result, 32'h55AA_55AA);
        chk("alu_strobe", bus_if.wb_rf_write_strobe, 4'b1111);
        tick();
        #1 chk("alu_wb_valid_after", bus_if.wb_valid, 0);

        // flush during WAIT, stale response dropped, next load gets its own data
        ex_load(3'd5, 32'h0000_5000, 5'd13, 1'b1);
        tick();
        ex_clear();
        bus_if.flush = 1'b1;
        #1 chk("flush_wb_valid", bus_if.wb_valid, 0);
        tick();
        bus_if.flush = 1'b0;
        #1 chk("flush_allow_in", bus_if.io_allow_in, 1);
        ex_load(3'd5, 32'h0000_6000, 5'd14, 1'b1);
        tick();
        ex_clear();
        resp(1'b1, 32'h1111_1111);
        #1;
        chk("discard_wb_valid", bus_if.wb_valid, 0);
        chk("discard_pending", bus_if.bp_data_pending, 1);
        tick();
        resp(1'b1, 32'h2222_2222);
        #1;
        chk("after_discard_wb_valid", bus_if.wb_valid, 1);
        chk("after_discard_result", bus_if.wb_final_result, 32'h2222_2222);
        tick();
        resp(1'b0, 32'h0);
        #1 chk("after_discard_idle", bus_if.wb_valid, 0);

        // flush kills a ready ALU entry and blocks the EX entry of that cycle
        ex_load(3'd0, 32'h0000_0042, 5'd15, 1'b0);
        tick();
        bus_if.flush = 1'b1;
        ex_load(3'd0, 32'h0000_0043, 5'd16, 1'b0);
        #1 chk("flush_alu_wb_valid", bus_if.wb_valid, 0);
        tick();
        bus_if.flush = 1'b0;
        ex_clear();
        #1 chk("flush_entry_dropped", bus_if.wb_valid, 0);

        // exception entry: no WAIT, write enable suppressed
        ex_load(3'd5, 32'h0000_7001, 5'd17, 1'b1);
        bus_if.ex_exception_valid = 1'b1;
        bus_if.ex_exception_code  = 5'd4;
        tick();
        ex_clear();
        #1;
        chk("exc_wb_valid", bus_if.wb_valid, 1);
        chk("exc_rf_we", bus_if.wb_rf_write_enabled, 0);
        chk("exc_bp_valid", bus_if.bp_valid, 0);
        chk("exc_valid", bus_if.wb_exception_valid, 1);
        chk("exc_code", bus_if.wb_exception_code, 5'd4);
        tick();
        #1 chk("exc_wb_valid_after", bus_if.wb_valid, 0);

        // mtc0 pass-through
        ex_load(3'd0, 32'h0, 5'd0, 1'b0);
        bus_if.ex_rf_write_enabled     = 1'b0;
        bus_if.ex_move_to_cp0          = 1'b1;
        bus_if.ex_rt_value             = 32'h1357_9BDF;
        bus_if.ex_cp0_address_register = 5'd12;
        bus_if.ex_in_delay_slot        = 1'b1;
        tick();
        ex_clear();
        #1;
        chk("mtc0_wb_valid", bus_if.wb_valid, 1);
        chk("mtc0_flag", bus_if.wb_move_to_cp0, 1);
        chk("mtc0_rt", bus_if.wb_rt_value, 32'h1357_9BDF);
        chk("mtc0_reg", bus_if.wb_cp0_address_register, 5'd12);
        chk("mtc0_bd", bus_if.wb_in_delay_slot, 1);
        chk("mtc0_bp_valid", bus_if.bp_valid, 0);
        tick();

        // reset while a load is outstanding
        ex_load(3'd5, 32'h0000_8000, 5'd18, 1'b1);
        tick();
        ex_clear();
        #1 chk("rst_wait_pending", bus_if.bp_data_pending, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("rst_wait_allow_in", bus_if.io_allow_in, 1);
        chk("rst_wait_pending_clr", bus_if.bp_data_pending, 0);
        chk("rst_wait_wb_valid", bus_if.wb_valid, 0);
        ex_load(3'd5, 32'h0000_9000, 5'd19, 1'b1);
        tick();
        ex_clear();
        resp(1'b1, 32'h0BAD_F00D);
        #1 chk("rst_next_result", bus_if.wb_final_result, 32'h0BAD_F00D);
        tick();
        resp(1'b0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
